// File: rtl/rocc_dispatch_ctrl.sv
// RoCC command dispatcher: in-order command FIFO feeding NUM_ACCEL accelerators with per-channel busy tracking.
// Optional per-channel busy timeout is enabled by defining ROCC_TIMEOUT_EN.
module rocc_dispatch_ctrl #(
  parameter int NUM_ACCEL      = 2,
  parameter int CMD_DEPTH      = 4,
  parameter int FUNCT_W        = 7,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 1024,
  localparam int SEL_W         = (NUM_ACCEL > 1) ? $clog2(NUM_ACCEL) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 is_rocc_instr,
  input  logic                 rocc_blocking,
  input  logic [SEL_W-1:0]     rocc_sel,
  input  logic [FUNCT_W-1:0]   rocc_funct,
  input  logic [DATA_W-1:0]    rocc_rs1,
  input  logic [DATA_W-1:0]    rocc_rs2,
  output logic                 stall,
  output logic [NUM_ACCEL-1:0] cmd_valid,
  input  logic [NUM_ACCEL-1:0] cmd_ready,
  output logic [FUNCT_W-1:0]   cmd_funct,
  output logic [DATA_W-1:0]    cmd_rs1,
  output logic [DATA_W-1:0]    cmd_rs2,
  input  logic [NUM_ACCEL-1:0] done,
  output logic [NUM_ACCEL-1:0] busy,
  output logic [NUM_ACCEL-1:0] timeout_err
);

  localparam int PTR_W = $clog2(CMD_DEPTH);

  typedef enum logic {ST_NORMAL, ST_DRAIN} state_t;

  generate
    if (NUM_ACCEL < 1 || CMD_DEPTH < 2 || (CMD_DEPTH & (CMD_DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 1)
    begin : g_param_check
      $error("rocc_dispatch_ctrl: illegal parameter combination");
    end
  endgenerate

  logic [SEL_W-1:0]   r_sel   [CMD_DEPTH];
  logic [FUNCT_W-1:0] r_funct [CMD_DEPTH];
  logic [DATA_W-1:0]  r_rs1   [CMD_DEPTH];
  logic [DATA_W-1:0]  r_rs2   [CMD_DEPTH];
  logic [PTR_W-1:0]   r_wptr, r_rptr;
  logic [PTR_W:0]     r_count;
  logic [NUM_ACCEL-1:0] r_busy;
  state_t             r_state, w_state_nxt;

  logic               w_push, w_pop, w_empty, w_full, w_idle;
  logic [SEL_W-1:0]   w_head_sel;
  logic [NUM_ACCEL-1:0] w_timeout;

  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == (PTR_W+1)'(CMD_DEPTH));
  assign w_idle     = w_empty && (r_busy == '0);
  assign w_head_sel = r_sel[r_rptr];
  assign cmd_funct  = r_funct[r_rptr];
  assign cmd_rs1    = r_rs1[r_rptr];
  assign cmd_rs2    = r_rs2[r_rptr];
  assign busy       = r_busy;

  // Only the head may issue; a busy target blocks everything behind it.
  always_comb begin
    cmd_valid = '0;
    for (int i = 0; i < NUM_ACCEL; i++) begin
      if (!w_empty && w_head_sel == SEL_W'(i) && !r_busy[i]) cmd_valid[i] = 1'b1;
    end
  end

  assign w_pop = |(cmd_valid & cmd_ready);

  always_comb begin
    w_state_nxt = r_state;
    stall       = 1'b0;
    w_push      = 1'b0;
    case (r_state)
      ST_NORMAL: begin
        if (is_rocc_instr) begin
          if (rocc_blocking) begin
            if (!w_idle) begin
              stall       = 1'b1;
              w_state_nxt = ST_DRAIN;
            end
          end else if (w_full) begin
            stall = 1'b1;
          end else begin
            w_push = 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        if (w_idle) w_state_nxt = ST_NORMAL;
        else        stall       = 1'b1;
      end
      default: w_state_nxt = ST_NORMAL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_NORMAL;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_sel[r_wptr]   <= rocc_sel;
      r_funct[r_wptr] <= rocc_funct;
      r_rs1[r_wptr]   <= rocc_rs1;
      r_rs2[r_wptr]   <= rocc_rs2;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_W'(1);
      if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PTR_W+1)'(1);
        2'b01:   r_count <= r_count - (PTR_W+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Issue only targets an idle channel, so set and clear never collide.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy <= '0;
    end else begin
      for (int i = 0; i < NUM_ACCEL; i++) begin
        if (w_pop && w_head_sel == SEL_W'(i)) r_busy[i] <= 1'b1;
        else if (done[i] || w_timeout[i])    r_busy[i] <= 1'b0;
      end
    end
  end

`ifdef ROCC_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TO_W-1:0]      r_to_cnt [NUM_ACCEL];
  logic [NUM_ACCEL-1:0] r_timeout_err;

  // Fires in the TIMEOUT_CYCLES-th busy cycle so busy is high exactly that many cycles.
  always_comb begin
    w_timeout = '0;
    for (int i = 0; i < NUM_ACCEL; i++) begin
      w_timeout[i] = r_busy[i] && (r_to_cnt[i] == TO_W'(TIMEOUT_CYCLES - 1));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_timeout_err <= '0;
      for (int i = 0; i < NUM_ACCEL; i++) r_to_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_ACCEL; i++) begin
        if (!r_busy[i]) r_to_cnt[i] <= '0;
        else            r_to_cnt[i] <= r_to_cnt[i] + TO_W'(1);
        if (w_timeout[i]) r_timeout_err[i] <= 1'b1;
      end
    end
  end

  assign timeout_err = r_timeout_err;
`else
  assign w_timeout   = '0;
  assign timeout_err = '0;
`endif

endmodule

// File: tb/tb_rocc_dispatch_ctrl.sv
// Directed bench for rocc_dispatch_ctrl: a cycle table for issue/backpressure plus hand sequences
// for head-of-line blocking, blocking-instruction drain, reset mid-operation and optional timeout.
module tb_rocc_dispatch_ctrl;
  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        is_rocc_instr = 1'b0;
  logic        rocc_blocking = 1'b0;
  logic [0:0]  rocc_sel = '0;
  logic [6:0]  rocc_funct = '0;
  logic [31:0] rocc_rs1 = '0, rocc_rs2 = '0;
  logic        stall;
  logic [1:0]  cmd_valid, cmd_ready = '0;
  logic [6:0]  cmd_funct;
  logic [31:0] cmd_rs1, cmd_rs2;
  logic [1:0]  done = '0, busy, timeout_err;

  int n_checks = 0;
  int n_err    = 0;

  rocc_dispatch_ctrl #(.NUM_ACCEL(2), .CMD_DEPTH(4), .FUNCT_W(7), .DATA_W(32), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .is_rocc_instr(is_rocc_instr), .rocc_blocking(rocc_blocking),
    .rocc_sel(rocc_sel), .rocc_funct(rocc_funct), .rocc_rs1(rocc_rs1), .rocc_rs2(rocc_rs2),
    .stall(stall), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_funct(cmd_funct),
    .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2), .done(done), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        instr;
    logic        blk;
    logic [0:0]  sel;
    logic [6:0]  funct;
    logic [31:0] rs1, rs2;
    logic [1:0]  ready, dn;
    logic        e_stall;
    logic [1:0]  e_valid;
    logic [6:0]  e_funct;
    logic [31:0] e_rs1, e_rs2;
    logic [1:0]  e_busy;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic instr, logic blk, logic [0:0] sel, logic [6:0] f,
                              logic [31:0] a, logic [31:0] b, logic [1:0] rdy, logic [1:0] dn,
                              logic es, logic [1:0] ev, logic [6:0] ef,
                              logic [31:0] ea, logic [31:0] eb, logic [1:0] eb_busy);
    vec_t v;
    v.instr = instr; v.blk = blk; v.sel = sel; v.funct = f; v.rs1 = a; v.rs2 = b;
    v.ready = rdy; v.dn = dn; v.e_stall = es; v.e_valid = ev; v.e_funct = ef;
    v.e_rs1 = ea; v.e_rs2 = eb; v.e_busy = eb_busy;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Apply inputs just after a rising edge, return at the following falling edge.
  task automatic drive(input logic instr, input logic blk, input logic [0:0] sel, input logic [6:0] f,
                       input logic [31:0] a, input logic [31:0] b, input logic [1:0] rdy,
                       input logic [1:0] dn);
    @(posedge clk);
    #1;
    is_rocc_instr = instr; rocc_blocking = blk; rocc_sel = sel; rocc_funct = f;
    rocc_rs1 = a; rocc_rs2 = b; cmd_ready = rdy; done = dn;
    @(negedge clk);
  endtask

  task automatic idle(input logic [1:0] rdy, input logic [1:0] dn);
    drive(1'b0, 1'b0, 1'b0, 7'h0, 32'h0, 32'h0, rdy, dn);
  endtask

  initial begin
    // reset state, single issue, done handling
    vecs.push_back(mk(0,0,0,0,0,0, 2'b00,2'b00, 0,2'b00,0,0,0, 2'b00));
    vecs.push_back(mk(1,0,1,5,32'hA,32'hB, 2'b11,2'b00, 0,2'b00,0,0,0, 2'b00));
    vecs.push_back(mk(0,0,0,0,0,0, 2'b11,2'b00, 0,2'b10,5,32'hA,32'hB, 2'b00));
    vecs.push_back(mk(0,0,0,0,0,0, 2'b11,2'b00, 0,2'b00,0,0,0, 2'b10));
    vecs.push_back(mk(0,0,0,0,0,0, 2'b00,2'b10, 0,2'b00,0,0,0, 2'b10));
    vecs.push_back(mk(0,0,0,0,0,0, 2'b00,2'b00, 0,2'b00,0,0,0, 2'b00));
    // fill to full with ready low, 5th push stalls until a pop
    vecs.push_back(mk(1,0,0,1,32'h101,32'h201, 2'b00,2'b00, 0,2'b00,0,0,0, 2'b00));
    vecs.push_back(mk(1,0,0,2,32'h102,32'h202, 2'b00,2'b00, 0,2'b01,1,32'h101,32'h201, 2'b00));
    vecs.push_back(mk(1,0,0,3,32'h103,32'h203, 2'b00,2'b00, 0,2'b01,1,32'h101,32'h201, 2'b00));
    vecs.push_back(mk(1,0,0,4,32'h104,32'h204, 2'b00,2'b00, 0,2'b01,1,32'h101,32'h201, 2'b00));
    vecs.push_back(mk(1,0,0,5,32'h105,32'h205, 2'b00,2'b00, 1,2'b01,1,32'h101,32'h201, 2'b00));
    vecs.push_back(mk(1,0,0,5,32'h105,32'h205, 2'b01,2'b00, 1,2'b01,1,32'h101,32'h201, 2'b00));
    vecs.push_back(mk(1,0,0,5,32'h105,32'h205, 2'b00,2'b00, 0,2'b00,0,0,0, 2'b01));
    vecs.push_back(mk(0,0,0,0,0,0, 2'b00,2'b00, 0,2'b00,0,0,0, 2'b01));
    vecs.push_back(mk(0,0,0,0,0,0, 2'b00,2'b01, 0,2'b00,0,0,0, 2'b01));
    vecs.push_back(mk(0,0,0,0,0,0, 2'b01,2'b00, 0,2'b01,2,32'h102,32'h202, 2'b00));
    vecs.push_back(mk(0,0,0,0,0,0, 2'b00,2'b01, 0,2'b00,0,0,0, 2'b01));
    vecs.push_back(mk(0,0,0,0,0,0, 2'b01,2'b00, 0,2'b01,3,32'h103,32'h203, 2'b00));
    vecs.push_back(mk(0,0,0,0,0,0, 2'b00,2'b01, 0,2'b00,0,0,0, 2'b01));
    vecs.push_back(mk(0,0,0,0,0,0, 2'b01,2'b00, 0,2'b01,4,32'h104,32'h204, 2'b00));
    vecs.push_back(mk(0,0,0,0,0,0, 2'b00,2'b01, 0,2'b00,0,0,0, 2'b01));
    vecs.push_back(mk(0,0,0,0,0,0, 2'b01,2'b00, 0,2'b01,5,32'h105,32'h205, 2'b00));
    vecs.push_back(mk(0,0,0,0,0,0, 2'b00,2'b01, 0,2'b00,0,0,0, 2'b01));
    // done while not busy is ignored
    vecs.push_back(mk(0,0,0,0,0,0, 2'b00,2'b11, 0,2'b00,0,0,0, 2'b00));
    vecs.push_back(mk(0,0,0,0,0,0, 2'b00,2'b00, 0,2'b00,0,0,0, 2'b00));

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    foreach (vecs[k]) begin
      vec_t v;
      v = vecs[k];
      if (k == 0) @(negedge clk);
      else drive(v.instr, v.blk, v.sel, v.funct, v.rs1, v.rs2, v.ready, v.dn);
      if (k == 0) begin
        is_rocc_instr = v.instr; cmd_ready = v.ready; done = v.dn; #1;
      end
      chk($sformatf("row%0d stall", k), {31'b0, stall}, {31'b0, v.e_stall});
      chk($sformatf("row%0d cmd_valid", k), {30'b0, cmd_valid}, {30'b0, v.e_valid});
      chk($sformatf("row%0d busy", k), {30'b0, busy}, {30'b0, v.e_busy});
      chk($sformatf("row%0d timeout_err", k), {30'b0, timeout_err}, 32'h0);
      if (v.e_valid != 2'b00) begin
        chk($sformatf("row%0d cmd_funct", k), {25'b0, cmd_funct}, {25'b0, v.e_funct});
        chk($sformatf("row%0d cmd_rs1", k), cmd_rs1, v.e_rs1);
        chk($sformatf("row%0d cmd_rs2", k), cmd_rs2, v.e_rs2);
      end
    end

    // head-of-line blocking: sel0 busy holds back a later sel1 entry
    drive(1, 0, 0, 7'h10, 0, 0, 2'b11, 2'b00);
    drive(1, 0, 0, 7'h11, 0, 0, 2'b11, 2'b00);
    chk("hol first issue valid", {30'b0, cmd_valid}, 32'h1);
    chk("hol first issue funct", {25'b0, cmd_funct}, 32'h10);
    drive(1, 0, 1, 7'h12, 0, 0, 2'b11, 2'b00);
    chk("hol blocked valid a", {30'b0, cmd_valid}, 32'h0);
    chk("hol busy a", {30'b0, busy}, 32'h1);
    idle(2'b11, 2'b00);
    chk("hol blocked valid b", {30'b0, cmd_valid}, 32'h0);
    idle(2'b11, 2'b01);
    chk("hol blocked valid c", {30'b0, cmd_valid}, 32'h0);
    idle(2'b11, 2'b00);
    chk("hol sel0 issues first", {30'b0, cmd_valid}, 32'h1);
    chk("hol sel0 funct", {25'b0, cmd_funct}, 32'h11);
    idle(2'b11, 2'b00);
    chk("hol sel1 issues next", {30'b0, cmd_valid}, 32'h2);
    chk("hol sel1 funct", {25'b0, cmd_funct}, 32'h12);
    idle(2'b00, 2'b00);
    chk("hol both busy", {30'b0, busy}, 32'h3);
    idle(2'b00, 2'b11);
    idle(2'b00, 2'b00);
    chk("hol all done", {30'b0, busy}, 32'h0);

    // blocking instruction with two queued entries and a busy channel
    drive(1, 0, 0, 7'h20, 0, 0, 2'b00, 2'b00);
    drive(1, 0, 0, 7'h21, 0, 0, 2'b00, 2'b00);
    drive(1, 0, 1, 7'h22, 0, 0, 2'b01, 2'b00);
    chk("drain pre pop funct", {25'b0, cmd_funct}, 32'h20);
    drive(1, 1, 0, 0, 0, 0, 2'b00, 2'b00);
    chk("drain stall enter", {31'b0, stall}, 32'h1);
    chk("drain busy", {30'b0, busy}, 32'h1);
    drive(1, 1, 0, 0, 0, 0, 2'b00, 2'b01);
    chk("drain stall 1", {31'b0, stall}, 32'h1);
    drive(1, 1, 0, 0, 0, 0, 2'b11, 2'b00);
    chk("drain stall 2", {31'b0, stall}, 32'h1);
    chk("drain issue sel0", {30'b0, cmd_valid}, 32'h1);
    drive(1, 1, 0, 0, 0, 0, 2'b11, 2'b00);
    chk("drain stall 3", {31'b0, stall}, 32'h1);
    chk("drain issue sel1", {30'b0, cmd_valid}, 32'h2);
    chk("drain issue sel1 funct", {25'b0, cmd_funct}, 32'h22);
    drive(1, 1, 0, 0, 0, 0, 2'b00, 2'b11);
    chk("drain stall 4", {31'b0, stall}, 32'h1);
    chk("drain busy both", {30'b0, busy}, 32'h3);
    drive(1, 1, 0, 0, 0, 0, 2'b00, 2'b00);
    chk("drain retire stall", {31'b0, stall}, 32'h0);
    drive(1, 0, 1, 7'h30, 32'h33, 32'h44, 2'b10, 2'b00);
    chk("post drain push stall", {31'b0, stall}, 32'h0);
    idle(2'b10, 2'b00);
    chk("post drain issue", {30'b0, cmd_valid}, 32'h2);
    chk("post drain rs1", cmd_rs1, 32'h33);
    idle(2'b00, 2'b10);
    chk("post drain busy", {30'b0, busy}, 32'h2);
    idle(2'b00, 2'b00);
    chk("post drain idle", {30'b0, busy}, 32'h0);

    // reset mid-operation discards queued and outstanding work
    drive(1, 0, 0, 7'h40, 0, 0, 2'b01, 2'b00);
    drive(1, 0, 1, 7'h41, 0, 0, 2'b00, 2'b00);
    chk("prerst valid", {30'b0, cmd_valid}, 32'h1);
    rst = 1'b1;
    idle(2'b00, 2'b00);
    rst = 1'b0;
    idle(2'b11, 2'b00);
    chk("rst valid cleared", {30'b0, cmd_valid}, 32'h0);
    chk("rst busy cleared", {30'b0, busy}, 32'h0);
    chk("rst stall", {31'b0, stall}, 32'h0);

`ifdef ROCC_TIMEOUT_EN
    begin
      int cnt;
      drive(1, 0, 0, 7'h50, 0, 0, 2'b01, 2'b00);
      idle(2'b01, 2'b00);
      chk("to issue", {30'b0, cmd_valid}, 32'h1);
      cnt = 0;
      for (int k = 0; k < 200; k++) begin
        idle(2'b00, 2'b00);
        if (busy[0]) cnt++;
        else break;
      end
      chk("to busy cycles", cnt, TO);
      chk("to err sticky", {30'b0, timeout_err}, 32'h1);
      idle(2'b00, 2'b00);
      chk("to err held", {30'b0, timeout_err}, 32'h1);
    end
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
